// File: rtl/round_robin_arbiter_n_req_locked_if.sv
// Request/grant bundle between N requesters and the locked round-robin arbiter.
// master: drives req/last, sees grant/grant_valid/grant_id; slave: the arbiter.
interface round_robin_arbiter_n_req_locked_if #(
  parameter int N = 4
);
  localparam int W = (N > 2) ? $clog2(N) : 1;

  logic [N-1:0] req;
  logic [N-1:0] last;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [W-1:0] grant_id;

  modport master (
    output req,
    output last,
    input  grant,
    input  grant_valid,
    input  grant_id
  );

  modport slave (
    input  req,
    input  last,
    output grant,
    output grant_valid,
    output grant_id
  );
endinterface

// File: rtl/round_robin_arbiter_n_req_locked.sv
// Locked round-robin arbiter: the owner keeps the grant until last or req drop.
// Ports: clk, rst (async high), bus.slave (req,last in; grant,grant_valid,grant_id out).
// Optional hold timeout: define ARB_TIMEOUT_EN (limit set by TIMEOUT).
module round_robin_arbiter_n_req_locked #(
  parameter int N       = 4,
  parameter int TIMEOUT = 16
) (
  input logic clk,
  input logic rst,
  round_robin_arbiter_n_req_locked_if.slave bus
);
  localparam int W = (N > 2) ? $clog2(N) : 1;

  if (N < 2 || N > 16 || TIMEOUT < 2) begin : g_bad_param
    $error("round_robin_arbiter_n_req_locked: illegal N or TIMEOUT");
  end

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [W-1:0] r_ptr;
  logic [W-1:0] w_ptr_nxt;
  logic [W-1:0] r_id;
  logic [W-1:0] w_id_nxt;
  logic [W-1:0] w_ptr_adv;
  logic [N-1:0] r_grant;
  logic [N-1:0] w_grant_nxt;
  logic [N-1:0] w_own_oh;
  logic [N-1:0] w_others;
  logic         r_valid;
  logic         w_new;
  logic         w_end;
  logic         w_tmo;
  logic [W:0]   w_pick_idle;
  logic [W:0]   w_pick_busy;

  // Returns {found, index} of the first set bit at or above p, wrapping at N.
  function automatic logic [W:0] f_pick(
    input logic [N-1:0] r,
    input logic [W-1:0] p
  );
    logic [W:0] res;
    logic [W:0] idx;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = {1'b0, p} + (W+1)'(k);
      if (idx >= (W+1)'(N)) idx = idx - (W+1)'(N);
      if (r[idx[W-1:0]]) res = {1'b1, idx[W-1:0]};
    end
    return res;
  endfunction

  assign w_own_oh  = {{(N-1){1'b0}}, 1'b1} << r_id;
  assign w_others  = bus.req & ~w_own_oh;
  assign w_ptr_adv = (r_id == W'(N - 1)) ? '0 : r_id + W'(1);

  // Owner is excluded here; it is re-granted only when nobody else asks.
  assign w_pick_idle = f_pick(bus.req, r_ptr);
  assign w_pick_busy = f_pick(w_others, w_ptr_adv);

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] r_cnt;

  assign w_tmo = (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_new || w_state_nxt == IDLE) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  assign w_end = !bus.req[r_id] || bus.last[r_id] || w_tmo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_id    <= '0;
      r_grant <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_id    <= w_id_nxt;
      r_grant <= w_grant_nxt;
      r_valid <= |w_grant_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_id_nxt    = r_id;
    w_new       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_pick_idle[W]) begin
          w_state_nxt = BUSY;
          w_id_nxt    = w_pick_idle[W-1:0];
          w_new       = 1'b1;
        end
      end
      BUSY: begin
        if (w_end) begin
          w_ptr_nxt = w_ptr_adv;
          w_new     = 1'b1;
          if (w_pick_busy[W]) begin
            w_id_nxt = w_pick_busy[W-1:0];
          end else if (bus.req[r_id]) begin
            w_id_nxt = r_id;
          end else begin
            w_state_nxt = IDLE;
            w_id_nxt    = '0;
            w_new       = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    w_grant_nxt = '0;
    if (w_state_nxt == BUSY) begin
      w_grant_nxt = {{(N-1){1'b0}}, 1'b1} << w_id_nxt;
    end
  end

  assign bus.grant       = r_grant;
  assign bus.grant_valid = r_valid;
  assign bus.grant_id    = r_id;
endmodule
